// File: rtl/player_ctrl.sv
// Player column controller: synchronises and debounces two raw buttons, then steps
// the column left/right on a divided tick. Optional macro PLAYER_CTRL_WRAP_EN wraps at edges.
module player_ctrl #(
  parameter int COL_MIN    = 0,
  parameter int COL_MAX    = 609,
  parameter int COL_INIT   = 305,
  parameter int STEP       = 4,
  parameter int STEP_DIV   = 262144,
  parameter int DEB_CYCLES = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_left,
  input  logic        btn_right,
  output logic [11:0] btn_col,
  output logic        moving,
  output logic        at_edge
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int SW = $clog2(STEP_DIV);

  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
  localparam logic [SW-1:0] STEP_LAST  = SW'(STEP_DIV - 1);
  localparam logic [11:0]   COL_MIN_C  = 12'(COL_MIN);
  localparam logic [11:0]   COL_MAX_C  = 12'(COL_MAX);
  localparam logic [11:0]   COL_INIT_C = 12'(COL_INIT);
  localparam logic [11:0]   STEP_C     = 12'(STEP);
  localparam logic [11:0]   LEFT_LIM   = 12'(COL_MIN + STEP);

  typedef enum logic [1:0] {
    IDLE,
    MOVE_L,
    MOVE_R
  } state_t;

  // Bit 0 is the left button, bit 1 the right button throughout.
  logic [1:0]    sync1_q, sync1_d;
  logic [1:0]    sync2_q, sync2_d;
  logic [1:0]    deb_q, deb_d;
  logic [DW-1:0] deb_cnt_q [2];
  logic [DW-1:0] deb_cnt_d [2];
  state_t        state_q, state_d;
  logic [SW-1:0] step_cnt_q, step_cnt_d;
  logic [11:0]   col_q, col_d;
  logic          tick;

  always_comb begin
    sync1_d = {btn_right, btn_left};
    sync2_d = sync1_q;
    for (int unsigned i = 0; i < 2; i++) begin
      deb_d[i]     = deb_q[i];
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (deb_q[0] && !deb_q[1]) begin
          state_d = MOVE_L;
        end else if (deb_q[1] && !deb_q[0]) begin
          state_d = MOVE_R;
        end
      end
      MOVE_L:  if (!deb_q[0] || deb_q[1]) state_d = IDLE;
      MOVE_R:  if (!deb_q[1] || deb_q[0]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign tick = (state_q != IDLE) && (step_cnt_q == STEP_LAST);

  always_comb begin
    step_cnt_d = '0;
    if (state_q != IDLE && !tick) begin
      step_cnt_d = step_cnt_q + 1'b1;
    end
  end

  // Compare before subtracting/adding so the 12-bit arithmetic never wraps.
  always_comb begin
    col_d = col_q;
    if (tick) begin
      if (state_q == MOVE_L) begin
        if (col_q >= LEFT_LIM) begin
          col_d = col_q - STEP_C;
        end else begin
`ifdef PLAYER_CTRL_WRAP_EN
          col_d = (col_q == COL_MIN_C) ? COL_MAX_C : COL_MIN_C;
`else
          col_d = COL_MIN_C;
`endif
        end
      end else if (state_q == MOVE_R) begin
        if ((col_q + STEP_C) <= COL_MAX_C) begin
          col_d = col_q + STEP_C;
        end else begin
`ifdef PLAYER_CTRL_WRAP_EN
          col_d = (col_q == COL_MAX_C) ? COL_MIN_C : COL_MAX_C;
`else
          col_d = COL_MAX_C;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_cnt_q  <= '{default: '0};
      state_q    <= IDLE;
      step_cnt_q <= '0;
      col_q      <= COL_INIT_C;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_cnt_q  <= deb_cnt_d;
      state_q    <= state_d;
      step_cnt_q <= step_cnt_d;
      col_q      <= col_d;
    end
  end

  assign btn_col = col_q;
  assign moving  = (state_q != IDLE);
  assign at_edge = (col_q == COL_MIN_C) || (col_q == COL_MAX_C);

  a_col_range: assert property (@(posedge clk) disable iff (!rst)
    (col_q >= COL_MIN_C) && (col_q <= COL_MAX_C));

endmodule

// File: tb/tb_player_ctrl.sv
// Randomised bench for player_ctrl against a history-based reference model of the
// sync/debounce/step rules, plus directed latency, glitch, clamp and reset checks.
module tb_player_ctrl;

  localparam int COL_MIN    = 0;
  localparam int COL_MAX    = 609;
  localparam int COL_INIT   = 305;
  localparam int STEP       = 4;
  localparam int STEP_DIV   = 8;
  localparam int DEB_CYCLES = 4;
  localparam int MAXC       = 20000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_left = 1'b0;
  logic        btn_right = 1'b0;
  logic [11:0] btn_col;
  logic        moving;
  logic        at_edge;

  int n_vec = 0;
  int n_err = 0;

  // Per-cycle history since the last reset release; index = cycle number.
  bit pin [2][MAXC];
  bit syn [2][MAXC];
  bit deb [2][MAXC];
  int dir [MAXC];
  int col [MAXC];
  int t;
  int mstart;

  player_ctrl #(
    .COL_MIN   (COL_MIN),
    .COL_MAX   (COL_MAX),
    .COL_INIT  (COL_INIT),
    .STEP      (STEP),
    .STEP_DIV  (STEP_DIV),
    .DEB_CYCLES(DEB_CYCLES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_left (btn_left),
    .btn_right(btn_right),
    .btn_col  (btn_col),
    .moving   (moving),
    .at_edge  (at_edge)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, t, got, exp);
    end
  endtask

  function automatic int edge_of(input int c);
    return (c == COL_MIN || c == COL_MAX) ? 1 : 0;
  endfunction

  task automatic model_init();
    t = 0;
    mstart = 0;
    for (int s = 0; s < 2; s++) begin
      syn[s][0] = 1'b0;
      deb[s][0] = 1'b0;
    end
    dir[0] = 0;
    col[0] = COL_INIT;
  endtask

  // A step moves the column; clamp at the edges, or wrap with a landing on the edge first.
  function automatic int step_col(input int c, input int d);
    int n;
    n = c + d * STEP;
`ifdef PLAYER_CTRL_WRAP_EN
    if (d < 0 && n < COL_MIN) n = (c == COL_MIN) ? COL_MAX : COL_MIN;
    if (d > 0 && n > COL_MAX) n = (c == COL_MAX) ? COL_MIN : COL_MAX;
`else
    if (n < COL_MIN) n = COL_MIN;
    if (n > COL_MAX) n = COL_MAX;
`endif
    return n;
  endfunction

  task automatic model_step();
    bit ok;
    bit l, r;
    for (int s = 0; s < 2; s++) begin
      syn[s][t] = (t >= 2) ? pin[s][t-2] : 1'b0;
      deb[s][t] = deb[s][t-1];
      if (t >= DEB_CYCLES) begin
        ok = 1'b1;
        for (int j = t - DEB_CYCLES; j < t; j++) begin
          if (syn[s][j] == deb[s][j] || deb[s][j] != deb[s][t-1]) ok = 1'b0;
        end
        if (ok) deb[s][t] = syn[s][t-1];
      end
    end
    l = deb[0][t-1];
    r = deb[1][t-1];
    dir[t] = dir[t-1];
    if (dir[t-1] == 0) begin
      if (l && !r) dir[t] = -1;
      else if (r && !l) dir[t] = 1;
    end else if (dir[t-1] < 0) begin
      if (!l || r) dir[t] = 0;
    end else begin
      if (!r || l) dir[t] = 0;
    end
    col[t] = col[t-1];
    if (dir[t-1] != 0 && ((t - 1 - mstart) % STEP_DIV) == STEP_DIV - 1)
      col[t] = step_col(col[t-1], dir[t-1]);
    if (dir[t-1] == 0 && dir[t] != 0) mstart = t;
  endtask

  task automatic check_model();
    check("btn_col", int'(btn_col), col[t]);
    check("moving", int'(moving), (dir[t] != 0) ? 1 : 0);
    check("at_edge", int'(at_edge), edge_of(col[t]));
  endtask

  task automatic drive(input bit l, input bit r);
    if (t >= MAXC - 1) begin
      $display("FAIL cycle_budget: got %0d cycles, expected fewer than %0d", t, MAXC - 1);
      $fatal(1);
    end
    btn_left  = l;
    btn_right = r;
    pin[0][t] = l;
    pin[1][t] = r;
    @(posedge clk);
    #1;
    t++;
    model_step();
    check_model();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_col", int'(btn_col), COL_INIT);
    check("rst_moving", int'(moving), 0);
    check("rst_edge", int'(at_edge), edge_of(COL_INIT));
    @(posedge clk);
    #1;
    btn_left  = 1'b0;
    btn_right = 1'b0;
    rst = 1'b1;
    model_init();
    check_model();
  endtask

  initial begin
    int kind;
    int len;
    t = 0;
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // Idle: column parked at its reset position.
    for (int i = 0; i < 100; i++) drive(1'b0, 1'b0);
    check("idle_col", int'(btn_col), 305);
    check("idle_moving", int'(moving), 0);

    // Left held from cycle 0: latency sync(2) + debounce(4) + FSM(1) + divider(8).
    do_reset();
    for (int i = 0; i < 23; i++) begin
      drive(1'b1, 1'b0);
      if (t == 6)  check("lat_moving6", int'(moving), 0);
      if (t == 7)  check("lat_moving7", int'(moving), 1);
      if (t == 14) check("lat_col14", int'(btn_col), 305);
      if (t == 15) check("lat_col15", int'(btn_col), 301);
      if (t == 23) check("lat_col23", int'(btn_col), 297);
    end

    // Continue to 281, then reset mid-move and re-measure full latency.
    while (t < 55) drive(1'b1, 1'b0);
    check("pre_rst_col", int'(btn_col), 281);
    check("pre_rst_moving", int'(moving), 1);
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0);
      if (t == 6)  check("rlat_moving6", int'(moving), 0);
      if (t == 14) check("rlat_col14", int'(btn_col), 305);
      if (t == 15) check("rlat_col15", int'(btn_col), 301);
    end

    // Short glitch never survives the debouncer.
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0);
    for (int i = 0; i < 40; i++) drive(1'b0, 1'b0);
    check("glitch_col", int'(btn_col), 305);
    check("glitch_moving", int'(moving), 0);

    // Right held to the edge and beyond.
    for (int i = 0; i < 700; i++) drive(1'b0, 1'b1);
`ifndef PLAYER_CTRL_WRAP_EN
    check("clamp_col", int'(btn_col), 609);
    check("clamp_edge", int'(at_edge), 1);
    check("clamp_moving", int'(moving), 1);
`endif
    // Both held: fall back to idle, column frozen.
    for (int i = 0; i < 40; i++) drive(1'b1, 1'b1);
    check("both_moving", int'(moving), 0);

    // Left held well past the left edge.
    for (int i = 0; i < 700; i++) drive(1'b1, 1'b0);
    for (int i = 0; i < 40; i++) drive(1'b0, 1'b0);

    // Randomised phases.
    for (int p = 0; p < 40; p++) begin
      kind = int'($urandom_range(0, 4));
      len  = int'($urandom_range(5, 150));
      for (int i = 0; i < len; i++) begin
        case (kind)
          0: drive(1'b0, 1'b0);
          1: drive(1'b1, 1'b0);
          2: drive(1'b0, 1'b1);
          3: drive(1'b1, 1'b1);
          default: drive(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
        endcase
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/player_ctrl.md
PLAYER_CTRL -- requirements
Module: player_ctrl

Interface
REQ-001 SHALL have parameter COL_MIN, default 0, leftmost legal player column.
REQ-002 SHALL have parameter COL_MAX, default 609, rightmost legal player column (640 - 31).
REQ-003 SHALL have parameter COL_INIT, default 305, column after reset.
REQ-004 SHALL have parameter STEP, default 4, pixels moved per step.
REQ-005 SHALL have parameter STEP_DIV, default 262144, clock cycles between steps.
REQ-006 SHALL have parameter DEB_CYCLES, default 65536, stable cycles needed to accept a button level change.
REQ-007 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-008 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-009 SHALL have port btn_left  input  1  raw asynchronous left button, active-high.
REQ-010 SHALL have port btn_right  input  1  raw asynchronous right button, active-high.
REQ-011 SHALL have port btn_col  output  12  player column, drives the player sprite's btn_col input.
REQ-012 SHALL have port moving  output  1  high when the FSM is not IDLE.
REQ-013 SHALL have port at_edge  output  1  high when btn_col equals COL_MIN or COL_MAX.

Function
REQ-014 SHALL pass each button through a 2-flop synchronizer; a level at a pin becomes the synced value 2 cycles later.
REQ-015 SHALL debounce each synced button separately: the debounced level takes the synced value after DEB_CYCLES consecutive cycles of disagreement; any agreement clears the counter.
REQ-016 SHALL implement FSM states IDLE, MOVE_L, MOVE_R, registered.
REQ-017 IDLE -> MOVE_L when deb_left and not deb_right; IDLE -> MOVE_R when deb_right and not deb_left; otherwise stay in IDLE.
REQ-018 MOVE_L -> IDLE when deb_left falls or deb_right rises; MOVE_R is symmetric; no direct MOVE_L <-> MOVE_R transition.
REQ-019 SHALL keep a step counter 0..STEP_DIV-1, held at 0 in IDLE, incrementing in MOVE_*, wrapping to 0; a step tick fires when the counter is at STEP_DIV-1.
REQ-020 On a tick in MOVE_L, btn_col SHALL become btn_col-STEP if btn_col >= COL_MIN+STEP, else COL_MIN; MOVE_R mirrors this, clamping to COL_MAX.
REQ-021 btn_col SHALL only change on a step tick and SHALL never leave [COL_MIN, COL_MAX].
REQ-022 Latency: synced level high at cycle t -> debounced at t+DEB_CYCLES -> MOVE_* at t+DEB_CYCLES+1 -> first btn_col change at t+DEB_CYCLES+1+STEP_DIV.
REQ-023 Both buttons held: SHALL stay in, or return to, IDLE; btn_col holds.
REQ-024 Once at a clamp limit, further ticks in the same direction SHALL leave btn_col unchanged, and moving SHALL stay high.
REQ-025 moving and at_edge SHALL be combinational decodes of the registered state and btn_col.
REQ-026 Arithmetic SHALL be 12-bit unsigned, with comparisons ordered so no subtraction underflows.
REQ-027 Legal parameters: COL_MIN <= COL_INIT <= COL_MAX <= 4095-STEP, STEP >= 1, STEP_DIV >= 2, DEB_CYCLES >= 1.

Reset
REQ-028 rst low SHALL asynchronously force: btn_col=COL_INIT, state IDLE, step counter 0, debounce counters 0, debounced levels 0, synchronizer flops 0.
REQ-029 With reset values, moving=0 and at_edge=(COL_INIT==COL_MIN or COL_INIT==COL_MAX).
REQ-030 Reset asserted mid-move SHALL abort the move; after release, no step SHALL occur before the full REQ-022 latency elapses again.

Configuration
REQ-031 Macro PLAYER_CTRL_WRAP_EN defined: a step past an edge SHALL wrap, so moving left from COL_MIN gives COL_MAX and moving right from COL_MAX gives COL_MIN.
REQ-032 With PLAYER_CTRL_WRAP_EN defined, any partial step that would overshoot an edge SHALL land exactly on that edge first.
REQ-033 Macro PLAYER_CTRL_WRAP_EN undefined: clamp behaviour per REQ-020/REQ-024.

Verification (DEB_CYCLES=4, STEP_DIV=8, STEP=4, defaults otherwise)
REQ-034 Reset then idle 100 cycles -> btn_col=305, moving=0, at_edge=0 throughout.
REQ-035 btn_left high from cycle 0 -> moving rises at cycle 7; btn_col=301 at cycle 15, 297 at cycle 23.
REQ-036 btn_left glitch high for 3 cycles -> moving stays 0 and btn_col stays 305.
REQ-037 btn_right held long enough -> btn_col steps to 609, then holds; at_edge=1; moving=1 while held.
REQ-038 Both buttons held -> moving=0 and btn_col unchanged; with PLAYER_CTRL_WRAP_EN, left held from COL_MIN -> btn_col=609 on the next tick.
REQ-039 rst pulsed low while btn_col=281 and moving -> btn_col=305 immediately, state IDLE; first step arrives at the full REQ-022 latency after release.
